// File: rtl/key_filter_nch.sv
// ---------------------------------------------------------------------------
// key_filter_nch : N-channel key debouncer with press/release/long/repeat strobes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_filter_nch #(
  parameter int N_KEYS       = 2,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  // The edge that leaves a debounce state is itself the last stable cycle.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 2);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PDEB = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_RDEB = 2'd3;

  logic [N_KEYS-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    logic          ks;
    logic [1:0]    state, state_nxt;
    logic [DW-1:0] deb_cnt, deb_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          rep_phase, rep_phase_nxt;
    logic          level, level_nxt;
    logic          press_q, release_q, long_q, repeat_q;
    logic          press_nxt, release_nxt, long_nxt, repeat_nxt;

    assign ks = sync2[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= S_IDLE;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
        level     <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state     <= state_nxt;
        deb_cnt   <= deb_nxt;
        hold_cnt  <= hold_nxt;
        rep_cnt   <= rep_nxt;
        rep_phase <= rep_phase_nxt;
        level     <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
        repeat_q  <= repeat_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      case (state)
        S_IDLE: if (!ks) state_nxt = S_PDEB;
        S_PDEB: begin
          if (ks)                        state_nxt = S_IDLE;
          else if (deb_cnt == DEB_LAST)  state_nxt = S_DOWN;
        end
        S_DOWN: if (ks) state_nxt = S_RDEB;
        S_RDEB: begin
          if (!ks)                       state_nxt = S_DOWN;
          else if (deb_cnt == DEB_LAST)  state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    always_comb begin
      deb_nxt       = deb_cnt;
      hold_nxt      = hold_cnt;
      rep_nxt       = rep_cnt;
      rep_phase_nxt = rep_phase;
      level_nxt     = level;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;
      repeat_nxt    = 1'b0;
      case (state)
        S_PDEB: begin
          if (state_nxt == S_DOWN) begin
            deb_nxt       = '0;
            hold_nxt      = '0;
            rep_nxt       = '0;
            rep_phase_nxt = 1'b0;
            level_nxt     = 1'b0;
            press_nxt     = 1'b1;
          end else if (state_nxt == S_IDLE) begin
            deb_nxt = '0;
          end else begin
            deb_nxt = deb_cnt + 1'b1;
          end
        end
        // Hold timing runs on the edge that leaves DOWN too; R_DEB freezes it.
        S_DOWN: begin
          deb_nxt = '0;
          if (!rep_phase) begin
            if (hold_cnt == LONG_LAST) begin
              long_nxt      = 1'b1;
              rep_phase_nxt = 1'b1;
              rep_nxt       = '0;
            end else begin
              hold_nxt = hold_cnt + 1'b1;
            end
          end else if (REPEAT_EN) begin
            if (rep_cnt == REP_LAST) begin
              repeat_nxt = 1'b1;
              rep_nxt    = '0;
            end else begin
              rep_nxt = rep_cnt + 1'b1;
            end
          end
        end
        S_RDEB: begin
          if (state_nxt == S_IDLE) begin
            deb_nxt       = '0;
            hold_nxt      = '0;
            rep_nxt       = '0;
            rep_phase_nxt = 1'b0;
            level_nxt     = 1'b1;
            release_nxt   = 1'b1;
          end else if (state_nxt == S_DOWN) begin
            deb_nxt = '0;
          end else begin
            deb_nxt = deb_cnt + 1'b1;
          end
        end
        default: deb_nxt = '0;
      endcase
    end

    assign key_state[g]   = level;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
    assign key_repeat[g]  = repeat_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_key_filter_nch.sv
// ---------------------------------------------------------------------------
// tb_key_filter_nch : directed self-checking bench for key_filter_nch
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_filter_nch;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_in;
  logic [1:0] key_state, key_press, key_release, key_long, key_repeat;
  logic [7:0] strb;

  int n_checks = 0;
  int n_pass   = 0;

  key_filter_nch #(
    .N_KEYS      (2),
    .DEBOUNCE_CYC(8),
    .LONG_CYC    (40),
    .REPEAT_CYC  (10),
    .REPEAT_EN   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

  // Bit map: [7:6] press, [5:4] release, [3:2] long, [1:0] repeat
  assign strb = {key_press, key_release, key_long, key_repeat};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    logic [1:0] es;
    rst_n  = 1'b0;
    key_in = 2'b00;
    step();
    step();
    n_checks++;
    if (strb !== 8'h00) $display("FAIL reset_strobes: got %b exp %b", strb, 8'h00);
    else n_pass++;
    n_checks++;
    if (key_state !== 2'b11) $display("FAIL reset_state: got %b exp %b", key_state, 2'b11);
    else n_pass++;
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      e = '0;
      e[7:6] = (k == 10) ? 2'b11 : 2'b00;
      e[5:4] = (k == 22) ? 2'b11 : 2'b00;
      es = (k >= 10 && k < 22) ? 2'b00 : 2'b11;
      n_checks++;
      if (strb !== e) $display("FAIL reset_held_strobes cyc %0d: got %b exp %b", k, strb, e);
      else n_pass++;
      n_checks++;
      if (key_state !== es) $display("FAIL reset_held_state cyc %0d: got %b exp %b", k, key_state, es);
      else n_pass++;
      if (k == 12) key_in = 2'b11;
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] e;
    logic [1:0] es;
    key_in = 2'b10;
    for (int k = 1; k <= 40; k++) begin
      step();
      e = '0;
      e[6] = (k == 10);
      e[4] = (k == 30);
      es = (k >= 10 && k < 30) ? 2'b10 : 2'b11;
      n_checks++;
      if (strb !== e) $display("FAIL clean_strobes cyc %0d: got %b exp %b", k, strb, e);
      else n_pass++;
      n_checks++;
      if (key_state !== es) $display("FAIL clean_state cyc %0d: got %b exp %b", k, key_state, es);
      else n_pass++;
      if (k == 20) key_in = 2'b11;
    end
  endtask

  task automatic test_bounce();
    logic [7:0] e;
    logic [1:0] es;
    key_in = 2'b10;
    for (int k = 1; k <= 25; k++) begin
      step();
      n_checks++;
      if (strb !== 8'h00) $display("FAIL bounce_strobes cyc %0d: got %b exp %b", k, strb, 8'h00);
      else n_pass++;
      n_checks++;
      if (key_state !== 2'b11) $display("FAIL bounce_state cyc %0d: got %b exp %b", k, key_state, 2'b11);
      else n_pass++;
      if (k == 5 || k == 11) key_in = 2'b11;
      if (k == 6) key_in = 2'b10;
    end
    key_in = 2'b10;
    for (int k = 1; k <= 35; k++) begin
      step();
      e = '0;
      e[6] = (k == 10);
      e[4] = (k == 30);
      es = (k >= 10 && k < 30) ? 2'b10 : 2'b11;
      n_checks++;
      if (strb !== e) $display("FAIL bounce_settle_strobes cyc %0d: got %b exp %b", k, strb, e);
      else n_pass++;
      n_checks++;
      if (key_state !== es) $display("FAIL bounce_settle_state cyc %0d: got %b exp %b", k, key_state, es);
      else n_pass++;
      if (k == 20) key_in = 2'b11;
    end
  endtask

  task automatic test_long_repeat();
    logic [7:0] e;
    logic [1:0] es;
    key_in = 2'b01;
    for (int k = 1; k <= 120; k++) begin
      step();
      e = '0;
      e[7] = (k == 10);
      e[5] = (k == 110);
      e[3] = (k == 50);
      e[1] = (k == 60 || k == 70 || k == 80 || k == 90 || k == 100);
      es = (k >= 10 && k < 110) ? 2'b01 : 2'b11;
      n_checks++;
      if (strb !== e) $display("FAIL long_strobes cyc %0d: got %b exp %b", k, strb, e);
      else n_pass++;
      n_checks++;
      if (key_state !== es) $display("FAIL long_state cyc %0d: got %b exp %b", k, key_state, es);
      else n_pass++;
      if (k == 100) key_in = 2'b11;
    end
  endtask

  task automatic test_bounce_hold();
    logic [7:0] e;
    logic [1:0] es;
    key_in = 2'b01;
    for (int k = 1; k <= 90; k++) begin
      step();
      e = '0;
      e[7] = (k == 10);
      e[5] = (k == 80);
      e[3] = (k == 54);
      e[1] = (k == 64);
      es = (k >= 10 && k < 80) ? 2'b01 : 2'b11;
      n_checks++;
      if (strb !== e) $display("FAIL hold_bounce_strobes cyc %0d: got %b exp %b", k, strb, e);
      else n_pass++;
      n_checks++;
      if (key_state !== es) $display("FAIL hold_bounce_state cyc %0d: got %b exp %b", k, key_state, es);
      else n_pass++;
      if (k == 30 || k == 70) key_in = 2'b11;
      if (k == 34) key_in = 2'b01;
    end
  endtask

  task automatic test_independence_reset();
    logic [7:0] e;
    logic [1:0] es;
    key_in = 2'b10;
    for (int k = 1; k <= 80; k++) begin
      step();
      e = '0;
      e[6] = (k == 10);
      e[7] = (k == 13);
      e[2] = (k == 50);
      e[3] = (k == 53);
      e[0] = (k == 60 || k == 70 || k == 80);
      e[1] = (k == 63 || k == 73);
      es = 2'b11;
      if (k >= 10) es[0] = 1'b0;
      if (k >= 13) es[1] = 1'b0;
      n_checks++;
      if (strb !== e) $display("FAIL indep_strobes cyc %0d: got %b exp %b", k, strb, e);
      else n_pass++;
      n_checks++;
      if (key_state !== es) $display("FAIL indep_state cyc %0d: got %b exp %b", k, key_state, es);
      else n_pass++;
      if (k == 3) key_in = 2'b00;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (strb !== 8'h00) $display("FAIL midreset_strobes: got %b exp %b", strb, 8'h00);
    else n_pass++;
    n_checks++;
    if (key_state !== 2'b11) $display("FAIL midreset_state: got %b exp %b", key_state, 2'b11);
    else n_pass++;
    key_in = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (strb !== 8'h00) $display("FAIL in_reset_strobes cyc %0d: got %b exp %b", k, strb, 8'h00);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_checks++;
      if (strb !== 8'h00) $display("FAIL post_reset_strobes cyc %0d: got %b exp %b", k, strb, 8'h00);
      else n_pass++;
      n_checks++;
      if (key_state !== 2'b11) $display("FAIL post_reset_state cyc %0d: got %b exp %b", k, key_state, 2'b11);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_bounce_hold();
    test_independence_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
